rs_syndrome_calculator: RTL and testbench
=========================================

# rs_syndrome_calculator

Computes the 2t Reed–Solomon syndromes S_k = r(α^(FCR+k)), k = 0..NSYM-1, of a received GF(2^8) codeword streamed in one byte at a time. It sits directly upstream of the error-locator stage in the decoder and time-multiplexes a single combinational GF(2^8) multiplier, one Horner update per cycle. It is programmable by primitive polynomial and presents the syndrome vector through a valid/ready handshake.

## Interface
- `NSYM`, 4: number of syndromes (2t); legal range 2..16.
- `FCR`, 0: first consecutive root exponent; legal values 0 or 1.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous active-low reset. The reset polarity and synchronicity are fixed.
- `poly`, in, 8: low byte of the primitive polynomial (x^8 implied), e.g. 8'h1D. Static while a codeword is in flight.
- `in_data`, in, 8: received symbol, highest-degree coefficient first.
- `in_valid`, in, 1: `in_data` is valid.
- `in_last`, in, 1: final symbol (degree 0) of the codeword; qualified by `in_valid`.
- `in_ready`, out, 1: block accepts a symbol this cycle.
- `syn`, out, 8*NSYM: syndromes; S_k occupies `syn[8k+7:8k]`.
- `syn_zero`, out, 1: all syndromes zero (no detectable error); valid with `syn_valid`.
- `syn_valid`, out, 1: syndrome vector available.
- `syn_ready`, in, 1: consumer accepts the syndrome vector.

## Operation
- The FSM has three states: ACCEPT, UPDATE and OUTPUT.
- **ACCEPT:**
  - `in_ready`=1.
  - On `in_valid`: latch `in_data` into `sym`, latch `in_last` into `last_f`, set k=0, load `root` = (FCR ? 8'h02 : 8'h01), then go to UPDATE.
- **UPDATE:** `in_ready`=0. Each cycle:
  - S_k <= gf_mul(S_k, root) ^ `sym`.
  - `root` <= xtime(`root`), where xtime(x) = {x[6:0],0} ^ (x[7] ? `poly` : 0).
  - k <= k+1.
  - After k=NSYM-1: go to OUTPUT if `last_f` is set, otherwise go to ACCEPT.
- **OUTPUT:**
  - `syn_valid`=1 and `in_ready`=0.
  - `syn` and `syn_zero` are held stable.
  - On `syn_ready`: clear all S_k to 0, then go to ACCEPT.
- All arithmetic is GF(2^8): addition is XOR, and multiplication is polynomial multiplication reduced by x^8+`poly`.
- Syndrome registers start at 0 for every codeword. The first symbol therefore yields S_k = r_(n-1).
- There is no length counter; the codeword is delimited only by `in_last`. A single-symbol codeword (`in_last` on the first beat) is legal.
- `syn_zero` is the registered NOR of all S_k. It is recomputed on entry to OUTPUT.
- `in_valid` while `in_ready`=0 is ignored; the source must hold the data.
- `in_last` without `in_valid` is ignored.
- `syn_valid` is asserted only in OUTPUT.

## Timing
- **Reset values:**
  - state=ACCEPT, S_k=0, k=0, `root`=0, `sym`=0, `last_f`=0.
  - Outputs: `in_ready`=1, `syn_valid`=0, `syn_zero`=0, `syn`=0.
- **Throughput:** one symbol per NSYM+1 cycles. A symbol accepted at edge t is followed by updates at edges t+1..t+NSYM, and `in_ready` rises after edge t+NSYM.
- **Latency:** the last symbol accepted at edge t gives `syn_valid` high after edge t+NSYM.
- The output handshake completes on the edge where `syn_valid`&`syn_ready`=1. `in_ready` is 1 in the following cycle. `syn_ready` held high gives zero bubbles.
- `syn_ready` asserted outside OUTPUT has no effect.
- **Reset mid-operation** (any state): immediately returns to the reset values. Any partial codeword is discarded, and the source must restart from the highest-degree symbol.
- Changing `poly` outside ACCEPT is illegal and gives undefined syndromes, but must not corrupt the FSM.

## Structure
- Shared package `rs_pkg`:
  - `GF_W`=8.
  - default polynomial constant `GF_POLY_DEFAULT`=8'h1D.
  - state enum for ACCEPT/UPDATE/OUTPUT.
  - xtime function.
- Sub-module `gf256_mul_poly`: combinational a·b mod (x^8+`poly`) with a runtime 8-bit `poly`. It is instantiated once, with its inputs muxed by k.
- The syndrome file is an NSYM×8 register array indexed by k.

## Test plan
- **Reset/idle:** assert `rst_n`=0 mid-UPDATE, release → `in_ready`=1, `syn_valid`=0, `syn`=0; a fresh codeword then produces correct syndromes.
- **Single symbol:** `poly`=1D, NSYM=4, FCR=0, send 8'h01 with `in_last` → `syn` = {01,01,01,01}, `syn_zero`=0; `syn_valid` rises 4 cycles after acceptance.
- **Three symbols:** send 01,00,00 (r=x^2) → S = 01,04,10,40.
- **Reduction check:** send 01,00,00,00,00 (r=x^4) → S = 01,10,1D,CD.
- **All-zero codeword:** send 255 bytes of 00 with `in_last` on the final byte → all S_k=0, `syn_zero`=1.
- **Backpressure:**
  - Hold `syn_ready`=0 for 5 cycles → `syn`/`syn_valid` stay stable, `in_ready`=0, and `in_valid` pulses are ignored.
  - Release `syn_ready` → ACCEPT next cycle with S_k cleared.
  - With FCR=1, r=x gives S = 02,04,08,10.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared GF(2^8) constants, FSM state encoding and the xtime helper.
package rs_pkg;
  localparam int GF_W = 8;
  localparam logic [GF_W-1:0] GF_POLY_DEFAULT = 8'h1D;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_UPDATE = 2'd1,
    ST_OUTPUT = 2'd2
  } rs_state_e;

  // Multiply by alpha (x): shift left, fold x^8 back in through the low poly byte.
  function automatic logic [GF_W-1:0] xtime(input logic [GF_W-1:0] x,
                                            input logic [GF_W-1:0] poly);
    return {x[GF_W-2:0], 1'b0} ^ (x[GF_W-1] ? poly : '0);
  endfunction
endpackage

// File: rtl/gf256_mul_poly.sv
// Combinational GF(2^8) multiplier with a runtime-selectable reduction polynomial.
module gf256_mul_poly
  import rs_pkg::*;
(
  input  logic [GF_W-1:0] a,
  input  logic [GF_W-1:0] b,
  input  logic [GF_W-1:0] poly,
  output logic [GF_W-1:0] p
);
  // Shift-and-add: accumulate a*x^i for every set bit i of b, reducing as we shift.
  always_comb begin
    logic [GF_W-1:0] acc;
    logic [GF_W-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < GF_W; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = xtime(sh, poly);
    end
    p = acc;
  end
endmodule

// File: rtl/rs_syndrome_calculator.sv
// Streaming RS syndrome calculator: one Horner step per cycle through a shared multiplier.
module rs_syndrome_calculator
  import rs_pkg::*;
#(
  parameter int NSYM = 4,
  parameter int FCR  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [GF_W-1:0]      poly,
  input  logic [GF_W-1:0]      in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [GF_W*NSYM-1:0] syn,
  output logic                 syn_zero,
  output logic                 syn_valid,
  input  logic                 syn_ready
);
  localparam int KW = $clog2(NSYM);
  localparam logic [KW-1:0]   K_LAST    = KW'(NSYM - 1);
  localparam logic [GF_W-1:0] ROOT_INIT = (FCR != 0) ? 8'h02 : 8'h01;

  rs_state_e state, state_nxt;
  logic [NSYM-1:0][GF_W-1:0] syn_q, syn_upd;
  logic [KW-1:0]             k;
  logic [GF_W-1:0]           root, sym, mul_a, mul_p;
  logic                      last_f, syn_zero_q;

  // Select the syndrome slot currently being updated as multiplier operand.
  always_comb begin
    mul_a = '0;
    for (int i = 0; i < NSYM; i++)
      if (k == KW'(i)) mul_a = syn_q[i];
  end

  gf256_mul_poly u_mul (
    .a    (mul_a),
    .b    (root),
    .poly (poly),
    .p    (mul_p)
  );

  // Syndrome array as it will look after this cycle's Horner step (feeds syn_zero).
  always_comb begin
    syn_upd = syn_q;
    for (int i = 0; i < NSYM; i++)
      if (k == KW'(i)) syn_upd[i] = mul_p ^ sym;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    syn_valid = 1'b0;
    unique case (state)
      ST_ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_UPDATE;
      end
      ST_UPDATE: begin
        if (k == K_LAST) state_nxt = last_f ? ST_OUTPUT : ST_ACCEPT;
      end
      ST_OUTPUT: begin
        syn_valid = 1'b1;
        if (syn_ready) state_nxt = ST_ACCEPT;
      end
      default: state_nxt = ST_ACCEPT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ACCEPT;
    else        state <= state_nxt;
  end

  // Datapath: symbol capture, per-root Horner update, clear on hand-off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syn_q      <= '0;
      k          <= '0;
      root       <= '0;
      sym        <= '0;
      last_f     <= 1'b0;
      syn_zero_q <= 1'b0;
    end else begin
      unique case (state)
        ST_ACCEPT: begin
          if (in_valid) begin
            sym    <= in_data;
            last_f <= in_last;
            k      <= '0;
            root   <= ROOT_INIT;
          end
        end
        ST_UPDATE: begin
          syn_q <= syn_upd;
          root  <= xtime(root, poly);
          k     <= (k == K_LAST) ? '0 : k + 1'b1;
          if (k == K_LAST && last_f) syn_zero_q <= ~|syn_upd;
        end
        ST_OUTPUT: begin
          if (syn_ready) syn_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign syn      = syn_q;
  assign syn_zero = syn_zero_q;
endmodule

// File: tb/tb_rs_syndrome_calculator.sv
// Directed bench: two instances (FCR=0 and FCR=1) share one stream and handshake.
module tb_rs_syndrome_calculator;
  import rs_pkg::*;

  localparam int NSYM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] poly = GF_POLY_DEFAULT;
  logic [7:0] in_data = '0;
  logic in_valid = 1'b0, in_last = 1'b0, syn_ready = 1'b0;
  logic in_ready0, in_ready1, syn_zero0, syn_zero1, syn_valid0, syn_valid1;
  logic [8*NSYM-1:0] syn0, syn1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rs_syndrome_calculator #(.NSYM(NSYM), .FCR(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .poly(poly), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready0), .syn(syn0), .syn_zero(syn_zero0),
    .syn_valid(syn_valid0), .syn_ready(syn_ready)
  );

  rs_syndrome_calculator #(.NSYM(NSYM), .FCR(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .poly(poly), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready1), .syn(syn1), .syn_zero(syn_zero1),
    .syn_valid(syn_valid1), .syn_ready(syn_ready)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Wait for in_ready (bounded), then present one symbol for exactly one accepting edge.
  task automatic send_sym(input logic [7:0] d, input logic last);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk("in_ready_timeout", 64'(in_ready0), 64'd1);
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Count edges from acceptance until syn_valid rises.
  task automatic wait_syn(output int cyc);
    cyc = 0;
    while (!syn_valid0 && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                           input logic ez0, input logic ez1);
    chk({tag, "_valid"}, 64'({syn_valid0, syn_valid1}), 64'b11);
    chk({tag, "_syn0"}, 64'(syn0), 64'(e0));
    chk({tag, "_syn1"}, 64'(syn1), 64'(e1));
    chk({tag, "_zero"}, 64'({syn_zero0, syn_zero1}), 64'({ez0, ez1}));
  endtask

  task automatic handoff(input string tag);
    @(negedge clk);
    syn_ready = 1'b1;
    @(posedge clk);
    #1;
    syn_ready = 1'b0;
    chk({tag, "_rdy_after"}, 64'({in_ready0, in_ready1}), 64'b11);
    chk({tag, "_vld_after"}, 64'({syn_valid0, syn_valid1}), 64'b00);
    chk({tag, "_cleared"}, 64'({syn0, syn1}), 64'd0);
  endtask

  initial begin
    int cyc;
    logic [31:0] hold0;

    // Reset state
    #12;
    chk("rst_in_ready", 64'({in_ready0, in_ready1}), 64'b11);
    chk("rst_syn_valid", 64'({syn_valid0, syn_valid1}), 64'b00);
    chk("rst_syn_zero", 64'({syn_zero0, syn_zero1}), 64'b00);
    chk("rst_syn", 64'({syn0, syn1}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single symbol: every syndrome equals the symbol; latency NSYM edges
    send_sym(8'h01, 1'b1);
    chk("single_busy", 64'(in_ready0), 64'd0);
    wait_syn(cyc);
    chk("single_latency", 64'(cyc), 64'(NSYM));
    check_out("single", 32'h01010101, 32'h01010101, 1'b0, 1'b0);
    handoff("single");

    // r = x^2
    send_sym(8'h01, 1'b0);
    send_sym(8'h00, 1'b0);
    send_sym(8'h00, 1'b1);
    wait_syn(cyc);
    check_out("x2", 32'h40100401, 32'h1D401004, 1'b0, 1'b0);
    handoff("x2");

    // r = x^4 exercises modular reduction
    send_sym(8'h01, 1'b0);
    for (int i = 0; i < 3; i++) send_sym(8'h00, 1'b0);
    send_sym(8'h00, 1'b1);
    wait_syn(cyc);
    check_out("x4", 32'hCD1D1001, 32'h4CCD1D10, 1'b0, 1'b0);
    handoff("x4");

    // Reset in the middle of UPDATE, then a fresh codeword
    send_sym(8'h55, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 64'({in_ready0, in_ready1}), 64'b11);
    chk("midrst_syn_valid", 64'({syn_valid0, syn_valid1}), 64'b00);
    chk("midrst_syn", 64'({syn0, syn1}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_sym(8'h01, 1'b0);
    send_sym(8'h00, 1'b0);
    send_sym(8'h00, 1'b1);
    wait_syn(cyc);
    check_out("postrst_x2", 32'h40100401, 32'h1D401004, 1'b0, 1'b0);
    handoff("postrst");

    // All-zero 255-byte codeword
    for (int i = 0; i < 254; i++) send_sym(8'h00, 1'b0);
    send_sym(8'h00, 1'b1);
    wait_syn(cyc);
    check_out("zero", 32'h0, 32'h0, 1'b1, 1'b1);
    handoff("zero");

    // Backpressure with r = x; stray in_valid pulses must be ignored
    send_sym(8'h01, 1'b0);
    send_sym(8'h00, 1'b1);
    wait_syn(cyc);
    check_out("rx", 32'h08040201, 32'h10080402, 1'b0, 1'b0);
    hold0 = syn0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_data  = 8'hFF;
      in_last  = 1'b1;
      in_valid = (i % 2) == 0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("bp_hold_syn0", 64'(syn0), 64'(hold0));
      chk("bp_hold_syn1", 64'(syn1), 64'h10080402);
      chk("bp_valid", 64'({syn_valid0, syn_valid1}), 64'b11);
      chk("bp_in_ready", 64'({in_ready0, in_ready1}), 64'b00);
    end
    handoff("bp");

    // One more codeword after backpressure confirms nothing leaked in
    send_sym(8'h01, 1'b1);
    wait_syn(cyc);
    check_out("after_bp", 32'h01010101, 32'h01010101, 1'b0, 1'b0);
    handoff("after_bp");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
